// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - program load / instruction issue bundle between sequencer and its user
interface instr_sequencer_if #(
    parameter int AW = 4
);
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic [31:0]   instrWord;
    logic          newInstr;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    modport master (
        input  load_en, load_addr, load_data, prog_len, start,
        output instrWord, newInstr, pc, busy, done
    );

    modport slave (
        output load_en, load_addr, load_data, prog_len, start,
        input  instrWord, newInstr, pc, busy, done
    );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - loadable program store issuing one instruction strobe every GAP+1 cycles
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int GAP   = 10
) (
    input logic               Clk,
    input logic               Reset,
    instr_sequencer_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam int LW = AW + 1;
    localparam int GW = $clog2(GAP + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [GW-1:0] GAP_L   = GW'(GAP);

    logic [31:0]   mem_q [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   instr_word_q, instr_word_d;
    logic          new_instr_q, new_instr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [AW-1:0] pc_inc;
    logic          last_slot;

    assign pc_inc    = pc_q + AW'(1);
    assign last_slot = (({1'b0, pc_q} + LW'(1)) == len_q);

    // Store has no reset so a program survives a mid-run abort.
    always_ff @(posedge Clk) begin
        if (Reset && (state_q == S_IDLE) && bus.load_en) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    // Outputs are computed on the transition into a state so they are valid for that state's cycle.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        gap_d        = gap_q;
        pc_d         = pc_q;
        instr_word_d = instr_word_q;
        new_instr_d  = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.prog_len == '0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        len_d        = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
                        pc_d         = '0;
                        instr_word_d = mem_q[0];
                        new_instr_d  = 1'b1;
                        busy_d       = 1'b1;
                        state_d      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                gap_d   = GAP_L;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) begin
                    if (last_slot) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        pc_d         = pc_inc;
                        instr_word_d = mem_q[pc_inc];
                        new_instr_d  = 1'b1;
                        state_d      = S_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            gap_q        <= '0;
            pc_q         <= '0;
            instr_word_q <= '0;
            new_instr_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            gap_q        <= gap_d;
            pc_q         <= pc_d;
            instr_word_q <= instr_word_d;
            new_instr_q  <= new_instr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.instrWord = instr_word_q;
    assign bus.newInstr  = new_instr_q;
    assign bus.pc        = pc_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;
    logic Clk = 1'b0;
    logic Reset;
    int   tot  = 0;
    int   pass = 0;

    logic [31:0] prog [6] = '{32'h8C010000, 32'h8C020001, 32'h8C030002,
                              32'h00222020, 32'h00832022, 32'hAC040003};

    instr_sequencer_if #(.AW(4)) bus ();

    instr_sequencer #(.DEPTH(16), .AW(4), .GAP(10)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.prog_len  = '0;
        bus.start     = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.load_en   = 1'($urandom);
            bus.load_addr = 4'($urandom);
            bus.load_data = $urandom;
            bus.prog_len  = 5'($urandom);
            bus.start     = 1'($urandom);
            step();
        end
        idle_inputs();
        tot++; if (bus.instrWord !== 32'h0) $display("FAIL reset_instrWord got %h exp 0", bus.instrWord); else pass++;
        tot++; if (bus.newInstr !== 1'b0) $display("FAIL reset_newInstr got %b exp 0", bus.newInstr); else pass++;
        tot++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else pass++;
        tot++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.done); else pass++;
        tot++; if (bus.pc !== 4'd0) $display("FAIL reset_pc got %0d exp 0", bus.pc); else pass++;
        Reset = 1'b1;
        step();
    endtask

    task automatic test_full_program();
        int strobes = 0, done_cnt = 0, done_cyc = -1, busy_bad = 0;
        for (int i = 0; i < 6; i++) begin
            bus.load_en = 1'b1; bus.load_addr = 4'(i); bus.load_data = prog[i];
            step();
        end
        idle_inputs();
        bus.prog_len = 5'd6; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (bus.newInstr === 1'b1) begin
                if (strobes < 6) begin
                    tot++;
                    if (bus.instrWord !== prog[strobes] || bus.pc !== 4'(strobes) || c != strobes * 11)
                        $display("FAIL full_strobe%0d got word %h pc %0d cyc %0d exp word %h pc %0d cyc %0d",
                                 strobes, bus.instrWord, bus.pc, c, prog[strobes], strobes, strobes * 11);
                    else pass++;
                end
                strobes++;
            end
            if (bus.done === 1'b1) begin done_cnt++; done_cyc = c; end
            if ((c < 66 && bus.busy !== 1'b1) || (c >= 66 && bus.busy !== 1'b0)) busy_bad++;
            step();
        end
        tot++; if (strobes != 6) $display("FAIL full_strobe_count got %0d exp 6", strobes); else pass++;
        tot++; if (done_cnt != 1 || done_cyc != 66) $display("FAIL full_done got count %0d cyc %0d exp count 1 cyc 66", done_cnt, done_cyc); else pass++;
        tot++; if (busy_bad != 0) $display("FAIL full_busy got %0d bad cycles exp 0", busy_bad); else pass++;
        tot++; if (bus.pc !== 4'd5 || bus.instrWord !== prog[5]) $display("FAIL full_hold got pc %0d word %h exp pc 5 word %h", bus.pc, bus.instrWord, prog[5]); else pass++;
    endtask

    task automatic test_zero_length();
        int stray = 0;
        bus.prog_len = 5'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        tot++; if (bus.done !== 1'b1) $display("FAIL zero_done got %b exp 1", bus.done); else pass++;
        tot++; if (bus.newInstr !== 1'b0 || bus.busy !== 1'b0) $display("FAIL zero_quiet got newInstr %b busy %b exp 0 0", bus.newInstr, bus.busy); else pass++;
        step();
        tot++; if (bus.done !== 1'b0) $display("FAIL zero_done_pulse got %b exp 0", bus.done); else pass++;
        for (int c = 0; c < 15; c++) begin
            if (bus.newInstr !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) stray++;
            step();
        end
        tot++; if (stray != 0) $display("FAIL zero_idle got %0d active cycles exp 0", stray); else pass++;
    endtask

    task automatic test_ignored_inputs();
        int strobes = 0, done_cnt = 0, done_cyc = -1;
        bus.prog_len = 5'd6; bus.start = 1'b1;
        step();
        for (int c = 0; c < 80; c++) begin
            if (bus.newInstr === 1'b1) begin
                if (strobes < 6) begin
                    tot++;
                    if (bus.instrWord !== prog[strobes] || bus.pc !== 4'(strobes) || c != strobes * 11)
                        $display("FAIL ign_strobe%0d got word %h pc %0d cyc %0d exp word %h pc %0d cyc %0d",
                                 strobes, bus.instrWord, bus.pc, c, prog[strobes], strobes, strobes * 11);
                    else pass++;
                end
                strobes++;
            end
            if (bus.done === 1'b1) begin done_cnt++; done_cyc = c; end
            if (c == 13) begin
                bus.start = 1'b1; bus.prog_len = 5'd3;
                bus.load_en = 1'b1; bus.load_addr = 4'd2; bus.load_data = 32'hFFFFFFFF;
            end else begin
                idle_inputs();
                bus.prog_len = 5'd6;
            end
            step();
        end
        tot++; if (strobes != 6) $display("FAIL ign_strobe_count got %0d exp 6", strobes); else pass++;
        tot++; if (done_cnt != 1 || done_cyc != 66) $display("FAIL ign_done got count %0d cyc %0d exp count 1 cyc 66", done_cnt, done_cyc); else pass++;
    endtask

    task automatic test_reset_mid_run();
        int stray = 0, strobes = 0, bad = 0, done_cnt = 0;
        bus.prog_len = 5'd6; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 25; c++) step();
        tot++; if (bus.busy !== 1'b1 || bus.pc !== 4'd2) $display("FAIL mid_prerun got busy %b pc %0d exp 1 2", bus.busy, bus.pc); else pass++;
        Reset = 1'b0;
        step();
        tot++; if (bus.busy !== 1'b0 || bus.newInstr !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL mid_reset_flags got busy %b newInstr %b done %b exp 0 0 0", bus.busy, bus.newInstr, bus.done); else pass++;
        tot++; if (bus.pc !== 4'd0 || bus.instrWord !== 32'h0) $display("FAIL mid_reset_regs got pc %0d word %h exp 0 0", bus.pc, bus.instrWord); else pass++;
        Reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.newInstr !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
            step();
        end
        tot++; if (stray != 0) $display("FAIL mid_no_done got %0d active cycles exp 0", stray); else pass++;
        bus.prog_len = 5'd6; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (bus.newInstr === 1'b1) begin
                if (strobes >= 6 || bus.instrWord !== prog[strobes] || c != strobes * 11) bad++;
                strobes++;
            end
            if (bus.done === 1'b1) done_cnt++;
            step();
        end
        tot++; if (strobes != 6 || bad != 0 || done_cnt != 1)
            $display("FAIL mid_replay got strobes %0d bad %0d done %0d exp 6 0 1", strobes, bad, done_cnt); else pass++;
    endtask

    task automatic test_clamp();
        int strobes = 0, bad = 0, done_cyc = -1;
        for (int i = 0; i < 16; i++) begin
            bus.load_en = 1'b1; bus.load_addr = 4'(i); bus.load_data = 32'hC0DE0000 + i;
            step();
        end
        idle_inputs();
        bus.prog_len = 5'd20; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 190; c++) begin
            if (bus.newInstr === 1'b1) begin
                if (strobes >= 16 || bus.instrWord !== 32'hC0DE0000 + strobes || bus.pc !== 4'(strobes) || c != strobes * 11) bad++;
                strobes++;
            end
            if (bus.done === 1'b1) done_cyc = c;
            step();
        end
        tot++; if (strobes != 16) $display("FAIL clamp_count got %0d exp 16", strobes); else pass++;
        tot++; if (bad != 0) $display("FAIL clamp_words got %0d bad strobes exp 0", bad); else pass++;
        tot++; if (bus.pc !== 4'd15 || bus.instrWord !== 32'hC0DE000F) $display("FAIL clamp_last got pc %0d word %h exp 15 c0de000f", bus.pc, bus.instrWord); else pass++;
        tot++; if (done_cyc != 176) $display("FAIL clamp_done got cyc %0d exp 176", done_cyc); else pass++;
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b1;
        test_reset();
        test_full_program();
        test_zero_length();
        test_ignored_inputs();
        test_reset_mid_run();
        test_clamp();
        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end
endmodule
